// File: rtl/m_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// m_ctrl_fsm -- multi-cycle control unit for the m_cpu datapath.
//
// Walks one instruction through IF/ID/EX/MEM/WB (3-5 cycles plus memory
// wait states) and drives every datapath strobe and mux select. Outputs are
// decoded combinationally from the current state (plus zero / mem_ready
// where needed), and all of them are forced to 0 while reset is asserted.
//
// Optional build macro: M_CTRL_HALT_EN -- opcode 0x3F enters a terminal HLT
// state that only reset leaves. Without it 0x3F is an illegal opcode.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   Opcode/func  IR[31:26] / IR[5:0], held stable by the IR for the instruction
//   zero         ALU zero flag (used only in EXB)
//   mem_ready    memory completes the current access this cycle
//   state_out    current state encoding (debug)
//   pc_write, pc_src, ir_write, mem_read, mem_write, iord, reg_write,
//   reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_sel, alu_op
//                datapath strobes and selects
//   instr_done   pulse on the last cycle of each instruction
//   illegal      pulse in ID on an unsupported opcode/func
//   instr_count  retired-instruction counter (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | IF  : fetch, PC+4, wait for mem_ready
//   1   | ID  : decode, precompute branch target
//   2   | EXR : R-type ALU operation
//   3   | EXI : addi / ori ALU operation
//   4   | EXA : lw / sw address calculation
//   5   | EXB : beq compare, conditional PC load (retires)
//   6   | JMP : jump (retires)
//   7   | WBR : R-type write-back (retires)
//   8   | WBI : immediate write-back (retires)
//   9   | MRD : memory read, wait for mem_ready
//  10   | MWR : memory write, wait for mem_ready (retires)
//  11   | WBL : load write-back (retires)
//  15   | HLT : halted (only with M_CTRL_HALT_EN)
// ---------------------------------------------------------------------------
module m_ctrl_fsm #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [3:0]         state_out,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_sel,
    output logic [2:0]         alu_op,
    output logic               instr_done,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_EXR = 4'd2,
        S_EXI = 4'd3,
        S_EXA = 4'd4,
        S_EXB = 4'd5,
        S_JMP = 4'd6,
        S_WBR = 4'd7,
        S_WBI = 4'd8,
        S_MRD = 4'd9,
        S_MWR = 4'd10,
        S_WBL = 4'd11,
        S_HLT = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef M_CTRL_HALT_EN
    localparam logic [5:0] OP_HLT   = 6'h3F;
`endif

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t state;
    state_t next_state;

    function automatic logic func_legal(input logic [5:0] fn);
        return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
               (fn == 6'h25) || (fn == 6'h2A);
    endfunction

    function automatic logic [2:0] func_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        op = ALU_ADD;
        case (fn)
            6'h22:   op = ALU_SUB;
            6'h24:   op = ALU_AND;
            6'h25:   op = ALU_OR;
            6'h2A:   op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

`ifdef M_CTRL_HALT_EN
    // Marks the first HLT cycle so the halt retires exactly once.
    logic hlt_first;
`endif

    // Everything stays at 0 while reset is low so a write in flight is
    // cut off immediately rather than at the next edge.
    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_sel    = 1'b0;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            case (state)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b = 2'b11;
                    ext_sel   = 1'b1;
                    case (Opcode)
                        OP_RTYPE: begin
                            if (func_legal(func)) begin
                                next_state = S_EXR;
                            end else begin
                                illegal    = 1'b1;
                                next_state = S_IF;
                            end
                        end
                        OP_ADDI, OP_ORI: next_state = S_EXI;
                        OP_LW, OP_SW:    next_state = S_EXA;
                        OP_BEQ:          next_state = S_EXB;
                        OP_J:            next_state = S_JMP;
`ifdef M_CTRL_HALT_EN
                        OP_HLT:          next_state = S_HLT;
`endif
                        default: begin
                            illegal    = 1'b1;
                            next_state = S_IF;
                        end
                    endcase
                end
                S_EXR: begin
                    alu_src_a  = 1'b1;
                    alu_op     = func_alu_op(func);
                    next_state = S_WBR;
                end
                S_EXI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (Opcode == OP_ORI) begin
                        alu_op = ALU_OR;
                    end else begin
                        ext_sel = 1'b1;
                    end
                    next_state = S_WBI;
                end
                S_EXA: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    ext_sel    = 1'b1;
                    next_state = (Opcode == OP_LW) ? S_MRD : S_MWR;
                end
                S_EXB: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_write   = zero;
                    pc_src     = 2'b01;
                    instr_done = 1'b1;
                    next_state = S_IF;
                end
                S_JMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    next_state = S_IF;
                end
                S_WBR: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_IF;
                end
                S_WBI: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_IF;
                end
                S_MRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        next_state = S_WBL;
                    end
                end
                S_MWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        next_state = S_IF;
                    end
                end
                S_WBL: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_IF;
                end
`ifdef M_CTRL_HALT_EN
                S_HLT: begin
                    instr_done = hlt_first;
                    next_state = S_HLT;
                end
`endif
                default: next_state = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IF;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (instr_done) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

`ifdef M_CTRL_HALT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hlt_first <= 1'b0;
        end else begin
            hlt_first <= (state == S_ID) && (next_state == S_HLT);
        end
    end
`endif

    assign state_out = state;

endmodule

// File: tb/tb_m_ctrl_fsm.sv
module tb_m_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic [5:0]  func;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  state_out;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_sel;
    logic [2:0]  alu_op;
    logic        instr_done;
    logic        illegal;
    logic [31:0] instr_count;

    m_ctrl_fsm #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .state_out(state_out), .pc_write(pc_write),
        .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
        logic       first;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_count = 0;

    // select vector layout: [11:10] pc_src [9] iord [8] reg_dst [7] mem_to_reg
    // [6] alu_src_a [5:4] alu_src_b [3] ext_sel [2:0] alu_op
    localparam logic [11:0] M_PCSRC = 12'hC00;
    localparam logic [11:0] M_IORD  = 12'h200;
    localparam logic [11:0] M_RDST  = 12'h100;
    localparam logic [11:0] M_MTR   = 12'h080;
    localparam logic [11:0] M_A     = 12'h040;
    localparam logic [11:0] M_B     = 12'h030;
    localparam logic [11:0] M_EXT   = 12'h008;
    localparam logic [11:0] M_OP    = 12'h007;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic is_bad(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return !(fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
            6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02: return 1'b0;
`ifdef M_CTRL_HALT_EN
            6'h3F:   return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] fn_op(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b000;
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    // strobe vector: {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done, illegal}
    function automatic void model(input exp_t e, output logic [6:0] stb,
                                  output logic [11:0] sel, output logic [11:0] msk);
        stb = '0; sel = '0; msk = '0;
        case (e.st)
            4'd0: begin
                stb[4] = 1'b1;
                if (e.rdy) begin stb[6] = 1'b1; stb[5] = 1'b1; msk |= M_PCSRC; end
                sel[5:4] = 2'b01;
                msk |= M_IORD | M_A | M_B | M_OP;
            end
            4'd1: begin
                stb[0] = is_bad(e.op, e.fn);
                sel[5:4] = 2'b11; sel[3] = 1'b1;
                msk |= M_A | M_B | M_EXT | M_OP;
            end
            4'd2: begin
                sel[6] = 1'b1; sel[2:0] = fn_op(e.fn);
                msk |= M_A | M_B | M_OP;
            end
            4'd3: begin
                sel[6] = 1'b1; sel[5:4] = 2'b10;
                if (e.op == 6'h08) sel[3] = 1'b1; else sel[2:0] = 3'b011;
                msk |= M_A | M_B | M_EXT | M_OP;
            end
            4'd4: begin
                sel[6] = 1'b1; sel[5:4] = 2'b10; sel[3] = 1'b1;
                msk |= M_A | M_B | M_EXT | M_OP;
            end
            4'd5: begin
                stb[6] = e.z; stb[1] = 1'b1;
                sel[11:10] = 2'b01; sel[6] = 1'b1; sel[2:0] = 3'b001;
                msk |= M_PCSRC | M_A | M_B | M_OP;
            end
            4'd6: begin
                stb[6] = 1'b1; stb[1] = 1'b1;
                sel[11:10] = 2'b10; msk |= M_PCSRC;
            end
            4'd7: begin
                stb[2] = 1'b1; stb[1] = 1'b1;
                sel[8] = 1'b1; msk |= M_RDST | M_MTR;
            end
            4'd8: begin
                stb[2] = 1'b1; stb[1] = 1'b1;
                msk |= M_RDST | M_MTR;
            end
            4'd9: begin
                stb[4] = 1'b1; sel[9] = 1'b1; msk |= M_IORD;
            end
            4'd10: begin
                stb[3] = 1'b1; stb[1] = e.rdy; sel[9] = 1'b1; msk |= M_IORD;
            end
            4'd11: begin
                stb[2] = 1'b1; stb[1] = 1'b1;
                sel[7] = 1'b1; msk |= M_RDST | M_MTR;
            end
            4'd15: begin
                stb[1] = e.first;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [6:0] obs_stb();
        return {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done, illegal};
    endfunction

    function automatic logic [11:0] obs_sel();
        return {pc_src, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_sel, alu_op};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [5:0] fn, input logic first);
        exp_t e;
        e.st = st; e.rdy = rdy; e.z = z; e.op = op; e.fn = fn; e.first = first;
        sb.push_back(e);
    endtask

    // Pops one expectation per cycle, drives its inputs and compares the
    // DUT outputs before the next rising edge.
    task automatic drain();
        exp_t e;
        logic [6:0]  stb;
        logic [11:0] sel, msk;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy; zero = e.z; Opcode = e.op; func = e.fn;
            #1;
            model(e, stb, sel, msk);
            check("state", 32'(state_out), 32'(e.st));
            check("strobes", 32'(obs_stb()), 32'(stb));
            check("selects", 32'(obs_sel() & msk), 32'(sel));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wif, input int wmem);
        for (int i = 0; i < wif; i++) push(4'd0, 1'b0, z, op, fn, 1'b0);
        push(4'd0, 1'b1, z, op, fn, 1'b0);
        push(4'd1, 1'b1, z, op, fn, 1'b0);
        if (!is_bad(op, fn)) begin
            exp_count++;
            case (op)
                6'h00: begin push(4'd2, 1'b1, z, op, fn, 1'b0); push(4'd7, 1'b1, z, op, fn, 1'b0); end
                6'h08, 6'h0D: begin push(4'd3, 1'b1, z, op, fn, 1'b0); push(4'd8, 1'b1, z, op, fn, 1'b0); end
                6'h23: begin
                    push(4'd4, 1'b1, z, op, fn, 1'b0);
                    for (int i = 0; i < wmem; i++) push(4'd9, 1'b0, z, op, fn, 1'b0);
                    push(4'd9, 1'b1, z, op, fn, 1'b0);
                    push(4'd11, 1'b1, z, op, fn, 1'b0);
                end
                6'h2B: begin
                    push(4'd4, 1'b1, z, op, fn, 1'b0);
                    for (int i = 0; i < wmem; i++) push(4'd10, 1'b0, z, op, fn, 1'b0);
                    push(4'd10, 1'b1, z, op, fn, 1'b0);
                end
                6'h04: push(4'd5, 1'b1, z, op, fn, 1'b0);
                6'h02: push(4'd6, 1'b1, z, op, fn, 1'b0);
                default: begin
                    push(4'd15, 1'b1, z, op, fn, 1'b1);
                    for (int i = 0; i < 11; i++) push(4'd15, 1'b1, z, op, fn, 1'b0);
                end
            endcase
        end
        drain();
        check("instr_count", instr_count, exp_count);
    endtask

    initial begin
        reset = 1'b0; Opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
        #20;
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_strobes", 32'(obs_stb()), 32'd0);
        check("rst_selects", 32'(obs_sel()), 32'd0);
        check("rst_count", instr_count, 32'd0);
        #32;
        reset = 1'b1;

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
        run_instr(6'h23, 6'h00, 1'b0, 2, 2);   // lw, 9 cycles
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
        run_instr(6'h3E, 6'h00, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'h00, 6'h21, 1'b0, 0, 0);   // illegal func
        run_instr(6'h00, 6'h22, 1'b0, 0, 0);   // sub
        run_instr(6'h00, 6'h24, 1'b0, 1, 0);   // and
        run_instr(6'h00, 6'h25, 1'b0, 0, 0);   // or
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0);   // slt
        run_instr(6'h08, 6'h00, 1'b0, 0, 0);   // addi
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0);   // ori
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0);   // sw
        run_instr(6'h2B, 6'h00, 1'b0, 1, 1);   // sw with waits
        run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j

        // Reset while a store is stalled in MWR.
        push(4'd0, 1'b1, 1'b0, 6'h2B, 6'h00, 1'b0);
        push(4'd1, 1'b1, 1'b0, 6'h2B, 6'h00, 1'b0);
        push(4'd4, 1'b1, 1'b0, 6'h2B, 6'h00, 1'b0);
        push(4'd10, 1'b0, 1'b0, 6'h2B, 6'h00, 1'b0);
        drain();
        check("mwr_hold_state", 32'(state_out), 32'd10);
        check("mwr_hold_write", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_write", 32'(mem_write), 32'd0);
        check("abort_state", 32'(state_out), 32'd0);
        check("abort_strobes", 32'(obs_stb()), 32'd0);
        check("abort_count", instr_count, 32'd0);
        exp_count = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // first edge after release fetches

        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // halt or illegal depending on build
`ifdef M_CTRL_HALT_EN
        check("hlt_stay", 32'(state_out), 32'd15);
        reset = 1'b0;
        #1;
        check("hlt_exit", 32'(state_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
